// File: rtl/dual_rail_decoder_if.sv
// dual_rail_decoder_if: dual-rail input bus, decoded output handshake and error status
//   in_t/in_f   : true/false rails, driven by the producer
//   out_data    : decoded single-rail word, valid while out_valid is high
//   out_ready   : consumer accepts out_data when high with out_valid
//   err_illegal : high while the decoder sits in its error state
//   err_timeout : one-cycle pulse on partial-codeword timeout
//   err_count   : saturating count of error entries
interface dual_rail_decoder_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_t;
    logic [WIDTH-1:0] in_f;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             err_illegal;
    logic             err_timeout;
    logic [7:0]       err_count;

    modport master (
        output in_t, in_f, out_ready,
        input  out_data, out_valid, err_illegal, err_timeout, err_count
    );

    modport slave (
        input  in_t, in_f, out_ready,
        output out_data, out_valid, err_illegal, err_timeout, err_count
    );
endinterface

// File: rtl/dual_rail_decoder.sv
// dual_rail_decoder: decodes a return-to-spacer dual-rail bus into single-rail words
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : dual_rail_decoder_if.slave (in_t, in_f, out_ready in; out_data, out_valid,
//         err_illegal, err_timeout, err_count out)
//   Optional macro DRDEC_TIMEOUT_EN: flags a partial codeword lingering TIMEOUT cycles.
module dual_rail_decoder #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input logic               clk,
    input logic               rst,
    dual_rail_decoder_if.slave bus
);
    typedef enum logic [1:0] {SPACER_WAIT, DATA_WAIT, HOLD, ERROR} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] smp_t_q, smp_f_q;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             illegal_q, illegal_d;
    logic             err_timeout_q, err_timeout_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             timeout_hit;

    // Pair classes over the sampled bus: 00 spacer, 10/01 data, 11 illegal.
    wire all_spacer  = ~|(smp_t_q | smp_f_q);
    wire any_illegal = |(smp_t_q & smp_f_q);
    wire all_valid   = &(smp_t_q ^ smp_f_q);

`ifdef DRDEC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] tmo_q, tmo_d;

    // Counts consecutive DATA_WAIT cycles holding a partial codeword; any other
    // sample or leaving DATA_WAIT restarts it.
    always_comb begin
        tmo_d       = '0;
        timeout_hit = 1'b0;
        if (state_q == DATA_WAIT && !all_spacer && !all_valid) begin
            timeout_hit = (tmo_q == CW'(TIMEOUT - 1));
            tmo_d       = timeout_hit ? '0 : tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk)
        tmo_q <= rst ? '0 : tmo_d;
`else
    localparam int unused_timeout = TIMEOUT;
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        case (state_q)
            SPACER_WAIT: state_d = any_illegal ? ERROR : all_spacer ? DATA_WAIT : SPACER_WAIT;
            DATA_WAIT:   state_d = (any_illegal || timeout_hit) ? ERROR : all_valid ? HOLD : DATA_WAIT;
            HOLD:        state_d = bus.out_ready ? SPACER_WAIT : HOLD;
            default:     state_d = all_spacer ? DATA_WAIT : ERROR;
        endcase
        data_d        = (state_q == DATA_WAIT && state_d == HOLD) ? smp_t_q : data_q;
        valid_d       = state_d == HOLD;
        illegal_d     = state_d == ERROR;
        err_timeout_d = timeout_hit;
        cnt_d         = (state_d == ERROR && state_q != ERROR && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= SPACER_WAIT;
            smp_t_q       <= '0;
            smp_f_q       <= '0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            illegal_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            smp_t_q       <= bus.in_t;
            smp_f_q       <= bus.in_f;
            data_q        <= data_d;
            valid_q       <= valid_d;
            illegal_q     <= illegal_d;
            err_timeout_q <= err_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.out_data    = data_q;
    assign bus.out_valid   = valid_q;
    assign bus.err_illegal = illegal_q;
    assign bus.err_timeout = err_timeout_q;
    assign bus.err_count   = cnt_q;
endmodule

// File: doc/dual_rail_decoder.md
DUAL_RAIL_DECODER -- requirements
Module: dual_rail_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of dual-rail bit pairs.
REQ-002 SHALL have parameter TIMEOUT, default 15, max cycles a partial codeword may persist (used only with DRDEC_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port in_t  input  WIDTH  true rails of the dual-rail bus.
REQ-006 SHALL have port in_f  input  WIDTH  false rails of the dual-rail bus.
REQ-007 SHALL have port out_data  output  WIDTH  decoded single-rail word.
REQ-008 SHALL have port out_valid  output  1  out_data holds a decoded word.
REQ-009 SHALL have port out_ready  input  1  consumer accepts word when high with out_valid.
REQ-010 SHALL have port err_illegal  output  1  high while in ERROR state.
REQ-011 SHALL have port err_timeout  output  1  one-cycle pulse on partial-codeword timeout.
REQ-012 SHALL have port err_count  output  8  saturating count of error entries.

Function
REQ-013 SHALL register in_t/in_f into a sample register every cycle; all decisions use the sampled value only.
REQ-014 SHALL classify each sampled pair: 00 spacer, 10 one, 01 zero, 11 illegal.
REQ-015 SHALL implement states SPACER_WAIT, DATA_WAIT, HOLD, ERROR.
REQ-016 SPACER_WAIT: any illegal pair -> ERROR; all pairs spacer -> DATA_WAIT; else stay.
REQ-017 DATA_WAIT: any illegal pair -> ERROR (priority over completion); all pairs valid (10/01) -> capture out_data = sampled in_t, go HOLD; else stay.
REQ-018 HOLD: out_valid = 1, out_data stable; out_valid && out_ready -> SPACER_WAIT; bus contents ignored in HOLD.
REQ-019 ERROR: err_illegal = 1; all pairs spacer -> DATA_WAIT; else stay.
REQ-020 Latency: complete codeword stable at inputs before edge k -> out_valid high after edge k+1.
REQ-021 Handshake with out_ready held high: out_valid SHALL be high exactly one cycle per word.
REQ-022 out_ready while out_valid = 0 SHALL have no effect.
REQ-023 err_count SHALL increment by 1 on each transition into ERROR and saturate at 255.
REQ-024 A spacer SHALL be required between consecutive words; two valid codewords without spacer yield one output word.

Reset
REQ-025 rst high at an edge SHALL force state SPACER_WAIT, out_data = 0, out_valid = 0, err_illegal = 0, err_timeout = 0, err_count = 0, sample register = 0, timeout counter = 0.
REQ-026 rst SHALL take priority over every transition, including mid-HOLD (pending word discarded).

Configuration
REQ-027 With macro DRDEC_TIMEOUT_EN defined: in DATA_WAIT, a counter SHALL count consecutive cycles where the sample is neither all-spacer nor all-valid; reaching TIMEOUT SHALL pulse err_timeout for one cycle and enter ERROR; counter clears on leaving DATA_WAIT or on an all-spacer sample.
REQ-028 Without DRDEC_TIMEOUT_EN: no counter; err_timeout tied 0; partial codewords wait indefinitely.

Verification
REQ-029 Reset, drive spacer, then in_t=0xA5 in_f=0x5A, out_ready=1 -> out_data=0xA5, out_valid high one cycle, 2 edges after codeword.
REQ-030 Codeword 0x3C with out_ready=0 for 5 cycles then 1 -> out_valid held 5+ cycles, out_data=0x3C stable, drops after handshake.
REQ-031 In DATA_WAIT drive in_t=0x01 in_f=0x01 -> err_illegal high, err_count=1; then spacer -> err_illegal low, next codeword 0xFF decoded.
REQ-032 Codeword 0x12 then, without spacer, 0x34 -> only 0x12 output; 0x34 output only after a spacer and re-drive.
REQ-033 DRDEC_TIMEOUT_EN, TIMEOUT=15: hold partial in_t=0x0F in_f=0x00 -> err_timeout pulses once after 15 partial cycles, ERROR entered; without macro no error, no output.
REQ-034 Assert rst during HOLD with out_valid=1 -> next cycle out_valid=0, out_data=0, state SPACER_WAIT, err_count=0.
